// File: rtl/placar_pkg.sv
// Shared constants and the FSM state encoding for the score/BCD front end.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package placar_pkg;

  localparam int SCORE_W_DEF   = 10;
  localparam int MAX_SCORE_DEF = 999;
  localparam int BCD_DIGITS    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STORE = 2'd3
  } state_t;

endpackage

// File: rtl/bin_bcd_serial.sv
// Serial double-dabble converter: binary score to three BCD nibbles.
// Latency: load edge plus SCORE_W shift edges; done_o is high during the final shift cycle.
// Backpressure: none; a load restarts the conversion, results hold until the next load.
module bin_bcd_serial
  import placar_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic               done_o,
  output logic [3:0]         bcd0_o,
  output logic [3:0]         bcd1_o,
  output logic [3:0]         bcd2_o
);

  localparam int REG_W = SCORE_W + 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_W - 1);

  logic [REG_W-1:0] sreg_q, sreg_d;
  logic [REG_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             last;

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    adj = sreg_q;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (sreg_q[SCORE_W + 4*d +: 4] >= 4'd5) begin
        adj[SCORE_W + 4*d +: 4] = sreg_q[SCORE_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign last = run_q && (cnt_q == CNT_LAST);

  // Load seeds the register; each running cycle does one correct-and-shift iteration.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (load_i) begin
      sreg_d = {{(4*BCD_DIGITS){1'b0}}, score_i};
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      // The top bit falls off: the hundreds carry is never needed for scores up to 999.
      sreg_d = {adj[REG_W-2:0], 1'b0};
      cnt_d  = cnt_q + CNT_ONE;
      if (last) begin
        run_d = 1'b0;
      end
    end
  end

  // Converter state register; reset abandons any conversion in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign done_o = last;
  assign bcd0_o = sreg_q[SCORE_W     +: 4];
  assign bcd1_o = sreg_q[SCORE_W + 4 +: 4];
  assign bcd2_o = sreg_q[SCORE_W + 8 +: 4];

endmodule

// File: rtl/placar_bcd.sv
// Score keeper: two saturating scores, converted to BCD and published as one coherent snapshot.
// Latency: outputs follow a score change 25 edges after it registers (IDLE, 2 x LOAD/10 SHIFT/STORE).
// Backpressure: none; points during a conversion set pending and trigger a follow-up conversion.
module placar_bcd
  import placar_pkg::*;
#(
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               point1,
  input  logic               point2,
  input  logic               clear_scores,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [3:0]         dig0_dec,
  output logic [3:0]         dig1_dec,
  output logic [3:0]         dig2_dec,
  output logic [3:0]         dig3_dec,
  output logic [3:0]         dig4_dec,
  output logic [3:0]         dig5_dec,
  output logic               busy
);

  localparam logic [SCORE_W-1:0] SC_ONE = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SC_MAX = SCORE_W'(MAX_SCORE);

  // Live scores and change tracking
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic               pending_q, pending_d;
  logic               changed;

  // Conversion FSM and snapshot latches
  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic [SCORE_W-1:0] lat1_q, lat1_d, lat2_q, lat2_d;
  logic [11:0]        hold_q, hold_d;

  // Published snapshot
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [23:0]        digs_q, digs_d;

  // Converter hookup
  logic               cv_load;
  logic [SCORE_W-1:0] cv_score;
  logic               cv_done;
  logic [3:0]         cv_b0, cv_b1, cv_b2;

  // Live score update: clear wins, otherwise saturating increments.
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (clear_scores) begin
      s1_d = '0;
      s2_d = '0;
    end else begin
      if (point1 && (s1_q != SC_MAX)) s1_d = s1_q + SC_ONE;
      if (point2 && (s2_q != SC_MAX)) s2_d = s2_q + SC_ONE;
    end
  end

  assign changed = (s1_d != s1_q) || (s2_d != s2_q);

  // Pending: a change on the same edge as IDLE->LOAD must survive the clear.
  always_comb begin
    pending_d = pending_q;
    if (changed) begin
      pending_d = 1'b1;
    end else if ((state_q == ST_IDLE) && pending_q) begin
      pending_d = 1'b0;
    end
  end

  // Conversion sequencing: score1 first (sel=0), then score2, then publish everything at once.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    lat1_d   = lat1_q;
    lat2_d   = lat2_q;
    hold_d   = hold_q;
    score1_d = score1_q;
    score2_d = score2_q;
    digs_d   = digs_q;
    cv_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          lat1_d  = s1_q;
          lat2_d  = s2_q;
          sel_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cv_load = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cv_done) state_d = ST_STORE;
      end
      ST_STORE: begin
        if (!sel_q) begin
          hold_d  = {cv_b2, cv_b1, cv_b0};
          sel_d   = 1'b1;
          state_d = ST_LOAD;
        end else begin
          score1_d = lat1_q;
          score2_d = lat2_q;
          digs_d   = {hold_q, cv_b2, cv_b1, cv_b0};
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cv_score = sel_q ? lat2_q : lat1_q;

  // All state registers; reset has priority and aborts any conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      pending_q <= 1'b0;
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      lat1_q    <= '0;
      lat2_q    <= '0;
      hold_q    <= '0;
      score1_q  <= '0;
      score2_q  <= '0;
      digs_q    <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
      lat1_q    <= lat1_d;
      lat2_q    <= lat2_d;
      hold_q    <= hold_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      digs_q    <= digs_d;
    end
  end

  bin_bcd_serial #(
    .SCORE_W (SCORE_W)
  ) u_conv (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (cv_load),
    .score_i (cv_score),
    .done_o  (cv_done),
    .bcd0_o  (cv_b0),
    .bcd1_o  (cv_b1),
    .bcd2_o  (cv_b2)
  );

  assign score1   = score1_q;
  assign score2   = score2_q;
  assign dig0_dec = digs_q[3:0];
  assign dig1_dec = digs_q[7:4];
  assign dig2_dec = digs_q[11:8];
  assign dig3_dec = digs_q[15:12];
  assign dig4_dec = digs_q[19:16];
  assign dig5_dec = digs_q[23:20];
  assign busy     = (state_q != ST_IDLE);

endmodule
